// File: rtl/ifetch_prefetch_queue_if.sv
// ifetch_prefetch_queue_if
//   Bundles the instruction-memory request/response bus, the EX redirect
//   port and the fetch-stage dequeue stream of the prefetch queue.
//   master : the prefetch queue (drives requests, dequeue stream, status)
//   slave  : the surroundings (memory, EX stage, fetch stage)
//   Signals:
//     imem_req_valid/ready/addr  request handshake, word-aligned byte address
//     imem_resp_valid/data       in-order responses, >= 1 cycle after accept
//     redirect/redirect_pc       flush and restart fetching
//     deq_valid/ready/ins/pc     head of queue towards the fetch stage
//     count                      allocated entries (filled + pending)
//     proto_err                  sticky unexpected-response flag
interface ifetch_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          deq_valid;
  logic          deq_ready;
  logic [31:0]   deq_ins;
  logic [31:0]   deq_pc;
  logic [CW-1:0] count;
  logic          proto_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect, redirect_pc,
    output deq_valid, deq_ins, deq_pc,
    input  deq_ready,
    output count, proto_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect, redirect_pc,
    input  deq_valid, deq_ins, deq_pc,
    output deq_ready,
    input  count, proto_err
  );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue
//   Instruction prefetch queue between an in-order, variable-latency
//   instruction memory and the fetch stage. Issues sequential word fetches,
//   buffers up to DEPTH instructions with their PCs and presents them as a
//   valid/ready stream. A redirect flushes the queue, restarts fetching at
//   the new PC and discards responses that were still in flight.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  ifetch_prefetch_queue_if.master (memory bus, redirect, dequeue
//          stream, count, proto_err)
//   Parameters:
//     DEPTH     queue entries, power of two, >= 2
//     RESET_PC  first fetch address after reset
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  ifetch_prefetch_queue_if.master bus
);
  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam int unsigned   CW   = PW + 1;
  localparam int unsigned   DW   = PW + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Control state
  logic [31:0]      r_fetch_pc;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_alloc;
  logic [PW-1:0]    r_fill;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_pend;      // allocated but not yet filled
  logic [DW-1:0]    r_drop;      // stale responses still to be discarded
  logic             r_proto_err;
  logic [DEPTH-1:0] r_filled;

  // Entry payload, qualified by r_filled so it needs no reset
  logic [31:0]      r_pc  [DEPTH];
  logic [31:0]      r_ins [DEPTH];

  logic             w_req_valid;
  logic             w_accept;
  logic             w_deq_valid;
  logic             w_deq;
  logic             w_resp_drop;
  logic             w_resp_fill;
  logic             w_resp_bad;
  logic [DW-1:0]    w_drop_sum;
  logic [DW-1:0]    w_drop_redir;
  logic [CW-1:0]    w_count_next;
  logic [CW-1:0]    w_pend_next;

  // Registered count gates the request, so a full queue never accepts in
  // the same cycle it dequeues.
  assign w_req_valid = ~rst & ~bus.redirect & (r_count < FULL);
  assign w_accept    = w_req_valid & bus.imem_req_ready;
  assign w_deq_valid = r_filled[r_head] & ~bus.redirect;
  assign w_deq       = w_deq_valid & bus.deq_ready;

  // Every outstanding memory request is either a pending entry or a stale
  // one counted in r_drop; a response with neither is a protocol error.
  assign w_drop_sum  = r_drop + DW'(r_pend);
  assign w_resp_bad  = bus.imem_resp_valid & (w_drop_sum == '0);
  assign w_resp_drop = bus.imem_resp_valid & ~bus.redirect & (r_drop != '0);
  assign w_resp_fill = bus.imem_resp_valid & ~bus.redirect & (r_drop == '0)
                       & (r_pend != '0);

  // On redirect all pending entries turn stale; a response arriving in the
  // same cycle retires the oldest outstanding request straight away.
  always_comb begin
    w_drop_redir = w_drop_sum;
    if (bus.imem_resp_valid && (w_drop_sum != '0)) begin
      w_drop_redir = w_drop_sum - 1'b1;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_accept && !w_deq) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_accept && w_deq) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_comb begin
    w_pend_next = r_pend;
    if (w_accept && !w_resp_fill) begin
      w_pend_next = r_pend + 1'b1;
    end else if (!w_accept && w_resp_fill) begin
      w_pend_next = r_pend - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_head      <= '0;
      r_alloc     <= '0;
      r_fill      <= '0;
      r_count     <= '0;
      r_pend      <= '0;
      r_drop      <= '0;
      r_proto_err <= 1'b0;
      r_filled    <= '0;
    end else begin
      if (w_resp_bad) begin
        r_proto_err <= 1'b1;
      end
      if (bus.redirect) begin
        r_fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
        r_head     <= '0;
        r_alloc    <= '0;
        r_fill     <= '0;
        r_count    <= '0;
        r_pend     <= '0;
        r_drop     <= w_drop_redir;
        r_filled   <= '0;
      end else begin
        r_count <= w_count_next;
        r_pend  <= w_pend_next;
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_alloc    <= r_alloc + 1'b1;
        end
        if (w_resp_drop) begin
          r_drop <= r_drop - 1'b1;
        end
        // Fill targets an unfilled entry and dequeue a filled one, so the
        // two never touch the same bit.
        if (w_resp_fill) begin
          r_filled[r_fill] <= 1'b1;
          r_fill           <= r_fill + 1'b1;
        end
        if (w_deq) begin
          r_filled[r_head] <= 1'b0;
          r_head           <= r_head + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc[r_alloc] <= r_fetch_pc;
    end
    if (w_resp_fill) begin
      r_ins[r_fill] <= bus.imem_resp_data;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.deq_valid      = w_deq_valid;
  assign bus.deq_ins        = r_ins[r_head];
  assign bus.deq_pc         = r_pc[r_head];
  assign bus.count          = r_count;
  assign bus.proto_err      = r_proto_err;
endmodule
